pipeline_imem_arbiter: RTL and testbench
========================================

PIPELINE_IMEM_ARBITER -- requirements
Module: pipeline_imem_arbiter

Interface
REQ-001 Parameter MAX_FETCH_BURST, default 8: consecutive contended fetch grants allowed before the loader is forced a grant; range 1..255.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 reset_ni  input  1  asynchronous, active-low reset.
REQ-004 load_done_i  input  1  one-cycle pulse; boot image fully written.
REQ-005 fetch_req_i  input  1  fetch stage requests an instruction word.
REQ-006 fetch_addr_i  input  32  fetch byte address (PC).
REQ-007 fetch_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 fetch_rvalid_o  output  1  fetch_rdata_o valid.
REQ-009 fetch_rdata_o  output  32  fetched instruction.
REQ-010 fetch_err_o  output  1  with fetch_rvalid_o: access was faulted.
REQ-011 load_req_i / load_we_i  input  1 / 1  loader request; 1 = write, 0 = read.
REQ-012 load_addr_i / load_wdata_i  input  32 / 32  loader byte address and write data.
REQ-013 load_gnt_o / load_rvalid_o  output  1 / 1  loader grant; read data valid (reads only).
REQ-014 load_rdata_o  output  32  loader read data.
REQ-015 mem_en_o / mem_we_o  output  1 / 1  IMEM access enable and write enable.
REQ-016 mem_addr_o  output  8  IMEM word index (256 x 32).
REQ-017 mem_wdata_o / mem_rdata_i  output / input  32 / 32  IMEM write data; synchronous read data, 1-cycle latency.

Function
REQ-018 The FSM SHALL have states BOOT and RUN; BOOT -> RUN on load_done_i; RUN is held until reset.
REQ-019 In BOOT, only the loader SHALL be granted; fetch_gnt_o SHALL be 0.
REQ-020 In RUN, grant SHALL be combinational in the request cycle, at most one grant per cycle; the requester SHALL hold req/addr/data until granted.
REQ-021 In RUN with only one requester, that requester SHALL be granted.
REQ-022 In RUN with both requesting, fetch SHALL win unless starve_cnt == MAX_FETCH_BURST, in which case the loader SHALL win.
REQ-023 starve_cnt (8 bit) SHALL increment on each contended fetch grant, clear on any loader grant or any cycle without load_req_i, and never exceed MAX_FETCH_BURST.
REQ-024 On a grant, mem_en_o SHALL be 1 and mem_addr_o = granted addr[9:2]; mem_we_o = load_we_i only for a loader grant; mem_wdata_o = load_wdata_i.
REQ-025 Read data SHALL be returned exactly one cycle after the grant: rvalid pulses for the owner recorded at grant, rdata = mem_rdata_i.
REQ-026 Loader writes SHALL NOT produce load_rvalid_o.
REQ-027 load_done_i in the same cycle as a loader grant SHALL complete that access; the transition takes effect next cycle.
REQ-028 Address bits [1:0] and [31:10] SHALL be ignored for mem_addr_o unless FETCH_ADDR_CHECK_EN is defined.
REQ-029 With no grant, mem_en_o and mem_we_o SHALL be 0 and both rvalid outputs SHALL be 0 in the following cycle.

Reset
REQ-030 Reset SHALL force state BOOT, starve_cnt 0 and pending-owner 0, and drive every output to 0, including fetch_rdata_o and load_rdata_o.
REQ-031 Reset asserted mid-access SHALL drop the pending response; no rvalid follows deassertion.

Configuration
REQ-032 With FETCH_ADDR_CHECK_EN defined, a granted fetch with addr[1:0] != 0 or addr[31:10] != 0 SHALL raise mem_en_o 0; next cycle fetch_rvalid_o = 1, fetch_err_o = 1, fetch_rdata_o = 32'h00000013 (NOP).
REQ-033 Without FETCH_ADDR_CHECK_EN, fetch_err_o SHALL be tied 0 and all fetches access memory per REQ-028.

Verification
REQ-034 Boot: reset, loader writes 0xDEADBEEF @0x10 while fetch_req_i = 1 -> fetch_gnt_o 0; after load_done_i, fetch @0x10 -> rvalid next cycle, rdata 0xDEADBEEF.
REQ-035 Starvation: RUN, both requesting continuously, MAX_FETCH_BURST = 8 -> 8 fetch grants, then 1 loader grant, then the cycle repeats.
REQ-036 Latency: fetch granted at cycle N -> fetch_rvalid_o only at N+1; back-to-back fetches @0x0, 0x4 -> rvalid at N+1, N+2 in order.
REQ-037 Reset mid-op: assert reset_ni = 0 in the cycle after a fetch grant -> all outputs 0, no rvalid after release, state BOOT.
REQ-038 Check on: fetch @0x00000402 -> mem_en_o 0, next cycle err 1, rdata 0x00000013; check off: mem_addr_o = 0x00, err 0.
REQ-039 Loader read in RUN @0x8 -> load_rvalid_o next cycle with stored word, fetch_rvalid_o stays 0.

Source files
------------

// File: rtl/pipeline_imem_arbiter.sv
// Two-requester arbiter (fetch stage vs. boot loader) in front of a 256x32 synchronous IMEM.
// Optional FETCH_ADDR_CHECK_EN: misaligned/out-of-range fetches answer with a faulted NOP.
module pipeline_imem_arbiter #(
  parameter int unsigned MAX_FETCH_BURST = 8
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        load_done_i,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic        fetch_gnt_o,
  output logic        fetch_rvalid_o,
  output logic [31:0] fetch_rdata_o,
  output logic        fetch_err_o,
  input  logic        load_req_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic        load_gnt_o,
  output logic        load_rvalid_o,
  output logic [31:0] load_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [7:0]  MAX_BURST = 8'(MAX_FETCH_BURST);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  state_t     state, state_nxt;
  logic [7:0] starve_cnt, starve_nxt;
  logic       fetch_gnt, load_gnt, fetch_bad;
  logic       pend_fetch, pend_load;

  // Only the word index reaches the IMEM; the remaining loader address bits are don't-care.
  logic unused_load_addr;
  assign unused_load_addr = ^{load_addr_i[31:10], load_addr_i[1:0]};

`ifdef FETCH_ADDR_CHECK_EN
  logic pend_err;
  assign fetch_bad = (fetch_addr_i[1:0] != 2'b00) || (fetch_addr_i[31:10] != 22'd0);
`else
  logic unused_fetch_addr;
  assign unused_fetch_addr = ^{fetch_addr_i[31:10], fetch_addr_i[1:0]};
  assign fetch_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= BOOT;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    state_nxt = state;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    if (reset_ni) begin
      case (state)
        BOOT: begin
          load_gnt = load_req_i;
          if (load_done_i) state_nxt = RUN;
        end
        RUN: begin
          if (fetch_req_i && !(load_req_i && starve_cnt == MAX_BURST)) fetch_gnt = 1'b1;
          else                                                         load_gnt  = load_req_i;
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  // Counts fetch wins while the loader waits; saturates at the burst limit, which forces the loader in.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!load_req_i || load_gnt)                         starve_nxt = '0;
    else if (fetch_gnt && starve_cnt < MAX_BURST)        starve_nxt = starve_cnt + 8'd1;
  end

  assign fetch_gnt_o = fetch_gnt;
  assign load_gnt_o  = load_gnt;

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (load_gnt) begin
      mem_en_o    = 1'b1;
      mem_we_o    = load_we_i;
      mem_addr_o  = load_addr_i[9:2];
      mem_wdata_o = load_wdata_i;
    end else if (fetch_gnt && !fetch_bad) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = fetch_addr_i[9:2];
      mem_wdata_o = load_wdata_i;
    end
  end

  // Response owner recorded at grant; data arrives from the IMEM one cycle later.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pend_fetch <= 1'b0;
      pend_load  <= 1'b0;
    end else begin
      pend_fetch <= fetch_gnt;
      pend_load  <= load_gnt && !load_we_i;
    end
  end

`ifdef FETCH_ADDR_CHECK_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) pend_err <= 1'b0;
    else           pend_err <= fetch_gnt && fetch_bad;
  end

  assign fetch_err_o   = pend_err;
  assign fetch_rdata_o = !pend_fetch ? '0 : (pend_err ? NOP : mem_rdata_i);
`else
  assign fetch_err_o   = 1'b0;
  assign fetch_rdata_o = pend_fetch ? mem_rdata_i : '0;
`endif

  assign fetch_rvalid_o = pend_fetch;
  assign load_rvalid_o  = pend_load;
  assign load_rdata_o   = pend_load ? mem_rdata_i : '0;

endmodule

// File: tb/tb_pipeline_imem_arbiter.sv
// Directed bench for pipeline_imem_arbiter with a behavioural 256x32 synchronous IMEM.
// Define FETCH_ADDR_CHECK_EN for both files to exercise the faulting-fetch path.
module tb_pipeline_imem_arbiter;
  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        load_done_i;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_gnt_o, fetch_rvalid_o, fetch_err_o;
  logic [31:0] fetch_rdata_o;
  logic        load_req_i, load_we_i;
  logic [31:0] load_addr_i, load_wdata_i;
  logic        load_gnt_o, load_rvalid_o;
  logic [31:0] load_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] imem [256];
  int checks = 0;
  int failures = 0;

  pipeline_imem_arbiter #(.MAX_FETCH_BURST(8)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .load_done_i(load_done_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
    .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o), .fetch_err_o(fetch_err_o),
    .load_req_i(load_req_i), .load_we_i(load_we_i), .load_addr_i(load_addr_i),
    .load_wdata_i(load_wdata_i), .load_gnt_o(load_gnt_o), .load_rvalid_o(load_rvalid_o),
    .load_rdata_o(load_rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) imem[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata_i      <= imem[mem_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    fetch_req_i  = 1'b0;
    load_req_i   = 1'b0;
    load_we_i    = 1'b0;
    load_done_i  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {31'd0, fetch_gnt_o | fetch_rvalid_o | fetch_err_o | load_gnt_o |
                         load_rvalid_o | mem_en_o | mem_we_o}, 32'd0);
    chk({tag, "_data"}, fetch_rdata_o | load_rdata_o | mem_wdata_o | {24'd0, mem_addr_o}, 32'd0);
  endtask

  // Loader write issued in the current (post-negedge) cycle; returns at the next negedge.
  task automatic load_wr(input logic [31:0] a, input logic [31:0] d, input logic done);
    load_req_i = 1'b1; load_we_i = 1'b1; load_addr_i = a; load_wdata_i = d; load_done_i = done;
    #1 chk("boot_wr_gnt", {31'd0, load_gnt_o}, 32'd1);
    @(negedge clk_i);
    chk("boot_wr_no_rvalid", {31'd0, load_rvalid_o}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    mem_rdata_i  = 32'd0;
    reset_ni     = 1'b0;
    idle();
    fetch_req_i  = 1'b1;
    load_req_i   = 1'b1;
    fetch_addr_i = 32'h10;
    load_addr_i  = 32'h10;
    load_wdata_i = 32'h5555_5555;
    #12 chk_all_zero("reset");
    @(negedge clk_i);
    idle();
    reset_ni = 1'b1;

    // BOOT: loader write while fetch also requests
    @(negedge clk_i);
    fetch_req_i = 1'b1; fetch_addr_i = 32'h10;
    load_req_i = 1'b1; load_we_i = 1'b1; load_addr_i = 32'h10; load_wdata_i = 32'hDEAD_BEEF;
    #1;
    chk("boot_fetch_gnt", {31'd0, fetch_gnt_o}, 32'd0);
    chk("boot_load_gnt",  {31'd0, load_gnt_o}, 32'd1);
    chk("boot_mem_en_we", {30'd0, mem_en_o, mem_we_o}, 32'd3);
    chk("boot_mem_addr",  {24'd0, mem_addr_o}, 32'h04);
    chk("boot_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    @(negedge clk_i);
    chk("boot_wr_no_rvalid", {31'd0, load_rvalid_o}, 32'd0);
    load_wr(32'h0, 32'h1111_1111, 1'b0);
    load_wr(32'h4, 32'h2222_2222, 1'b0);
    load_wr(32'h8, 32'h3333_3333, 1'b1);
    idle();

    // RUN: fetch the boot-written word
    fetch_req_i = 1'b1; fetch_addr_i = 32'h10;
    #1 chk("run_fetch_gnt", {31'd0, fetch_gnt_o}, 32'd1);
    chk("run_fetch_addr", {24'd0, mem_addr_o}, 32'h04);
    @(negedge clk_i);
    chk("run_fetch_rvalid", {31'd0, fetch_rvalid_o}, 32'd1);
    chk("run_fetch_rdata", fetch_rdata_o, 32'hDEAD_BEEF);
    chk("run_fetch_err", {31'd0, fetch_err_o}, 32'd0);

    // Back-to-back fetches 0x0, 0x4
    fetch_addr_i = 32'h0;
    #1 chk("b2b_gnt0", {31'd0, fetch_gnt_o}, 32'd1);
    @(negedge clk_i);
    chk("b2b_rvalid0", {31'd0, fetch_rvalid_o}, 32'd1);
    chk("b2b_rdata0", fetch_rdata_o, 32'h1111_1111);
    fetch_addr_i = 32'h4;
    #1 chk("b2b_gnt1", {31'd0, fetch_gnt_o}, 32'd1);
    @(negedge clk_i);
    chk("b2b_rvalid1", {31'd0, fetch_rvalid_o}, 32'd1);
    chk("b2b_rdata1", fetch_rdata_o, 32'h2222_2222);
    idle();
    #1 chk("idle_mem_en", {30'd0, mem_en_o, mem_we_o}, 32'd0);
    @(negedge clk_i);
    chk("idle_no_rvalid", {30'd0, fetch_rvalid_o, load_rvalid_o}, 32'd0);

    // Loader read in RUN
    load_req_i = 1'b1; load_we_i = 1'b0; load_addr_i = 32'h8;
    #1 chk("ld_rd_gnt", {30'd0, load_gnt_o, mem_we_o}, 32'd2);
    @(negedge clk_i);
    chk("ld_rd_rvalid", {30'd0, load_rvalid_o, fetch_rvalid_o}, 32'd2);
    chk("ld_rd_rdata", load_rdata_o, 32'h3333_3333);
    idle();
    @(negedge clk_i);

    // Starvation: both requesting continuously -> 8 fetch, 1 loader, repeat
    fetch_req_i = 1'b1; fetch_addr_i = 32'h4;
    load_req_i = 1'b1; load_we_i = 1'b0; load_addr_i = 32'h0;
    for (int i = 0; i < 18; i++) begin
      logic exp_f;
      exp_f = ((i % 9) != 8);
      #1;
      chk($sformatf("starve_fgnt%0d", i), {31'd0, fetch_gnt_o}, {31'd0, exp_f});
      chk($sformatf("starve_lgnt%0d", i), {31'd0, load_gnt_o}, {31'd0, !exp_f});
      @(negedge clk_i);
    end
    idle();
    @(negedge clk_i);

    // Out-of-range / misaligned fetch address
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0000_0402;
`ifdef FETCH_ADDR_CHECK_EN
    #1 chk("chk_mem_en", {31'd0, mem_en_o}, 32'd0);
    chk("chk_gnt", {31'd0, fetch_gnt_o}, 32'd1);
    @(negedge clk_i);
    chk("chk_err", {30'd0, fetch_rvalid_o, fetch_err_o}, 32'd3);
    chk("chk_nop", fetch_rdata_o, 32'h0000_0013);
`else
    #1 chk("nochk_mem_addr", {23'd0, mem_en_o, mem_addr_o}, 32'h100);
    @(negedge clk_i);
    chk("nochk_err", {30'd0, fetch_rvalid_o, fetch_err_o}, 32'd2);
    chk("nochk_rdata", fetch_rdata_o, 32'h1111_1111);
`endif
    idle();
    @(negedge clk_i);

    // Reset in the cycle after a fetch grant
    fetch_req_i = 1'b1; fetch_addr_i = 32'h10;
    #1 chk("rst_pre_gnt", {31'd0, fetch_gnt_o}, 32'd1);
    @(posedge clk_i);
    #1 reset_ni = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk_i);
    idle();
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_no_rvalid", {30'd0, fetch_rvalid_o, load_rvalid_o}, 32'd0);
    fetch_req_i = 1'b1;
    #1 chk("rst_boot_fgnt", {31'd0, fetch_gnt_o}, 32'd0);
    load_req_i = 1'b1; load_we_i = 1'b0; load_addr_i = 32'h10;
    #1 chk("rst_boot_lgnt", {30'd0, load_gnt_o, fetch_gnt_o}, 32'd2);
    @(negedge clk_i);
    chk("rst_boot_rd", load_rdata_o, 32'hDEAD_BEEF);
    idle();
    @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
